// File: rtl/ara_pkg.sv
// Shared Ara types: element width, broadcast sequencer state and job configuration.
package ara_pkg;

  localparam int unsigned ELEN = 64;
  typedef logic [ELEN-1:0] elen_t;

  localparam int unsigned BcMaxBLen   = 32;
  localparam int unsigned BcRepWidth  = 16;
  localparam int unsigned BcBLenWidth = $clog2(BcMaxBLen) + 1;

  typedef enum logic [1:0] {
    BC_IDLE,
    BC_FETCH,
    BC_ISSUE,
    BC_DONE
  } bc_state_e;

  typedef struct packed {
    logic [BcBLenWidth-1:0] blen;
    logic [BcRepWidth-1:0]  reps;
  } bc_cfg_t;

endpackage

// File: rtl/bc_operand_sequencer.sv
// Lane-0 broadcast sequencer: pops fp32 scalars from the broadcast buffer and
// issues each one, replicated into both halves of an operand, a programmed number of times.
module bc_operand_sequencer
  import ara_pkg::*;
#(
  parameter int unsigned NrLanes  = 0,
  parameter int unsigned MaxBLen  = BcMaxBLen,
  parameter int unsigned RepWidth = BcRepWidth,
  localparam int unsigned BLenWidth = $clog2(MaxBLen) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [BLenWidth-1:0] cfg_blen_i,
  input  logic [RepWidth-1:0]  cfg_reps_i,
  input  logic                 abort_i,
  input  elen_t                bc_data_i,
  input  logic                 bc_data_valid_i,
  output logic                 bc_data_ready_o,
  output logic                 bc_data_invalidate_o,
  output elen_t                operand_o,
  output logic                 operand_valid_o,
  input  logic                 operand_ready_i,
  output logic                 operand_last_o,
  output logic                 done_o,
  output logic                 busy_o
);

  // NrLanes == 0 means the lane count is not known here, so nothing to check.
  localparam int unsigned LaneDiv = (NrLanes == 0) ? 1 : NrLanes;

  if (NrLanes != 0 && (MaxBLen % LaneDiv) != 0) begin : gen_lane_check
    $error("MaxBLen must be a multiple of NrLanes");
  end

  if (BLenWidth != BcBLenWidth || RepWidth != BcRepWidth) begin : gen_cfg_width_check
    $error("bc_cfg_t field widths do not match MaxBLen/RepWidth");
  end

  bc_state_e            state_q;
  bc_cfg_t              cfg_q;
  logic [BLenWidth-1:0] sc_q;
  logic [RepWidth-1:0]  rc_q;
  logic [31:0]          scalar_q;
  logic                 zero_job_q;

  logic abort_act, cfg_hs, op_hs, fetch_hs, bypass;
  logic rep_last, scalar_last;

  assign rep_last    = (rc_q == cfg_q.reps - RepWidth'(1));
  assign scalar_last = (sc_q == cfg_q.blen - BLenWidth'(1));

  // An abort masks every handshake in its cycle, so nothing is popped or issued.
  assign abort_act       = abort_i && (state_q != BC_IDLE);
  assign cfg_ready_o     = (state_q == BC_IDLE) && !abort_i;
  assign cfg_hs          = cfg_valid_i && cfg_ready_o;
  assign operand_valid_o = (state_q == BC_ISSUE) && !abort_i;
  assign op_hs           = operand_valid_o && operand_ready_i;
  assign bypass          = op_hs && rep_last && !scalar_last;
  assign bc_data_ready_o = ((state_q == BC_FETCH) && !abort_i) || bypass;
  assign fetch_hs        = bc_data_ready_o && bc_data_valid_i;

  assign operand_o            = {scalar_q, scalar_q};
  assign operand_last_o       = operand_valid_o && rep_last && scalar_last;
  assign done_o               = (state_q == BC_DONE) && !abort_i;
  assign bc_data_invalidate_o = abort_act || ((state_q == BC_DONE) && !zero_job_q);
  assign busy_o               = (state_q != BC_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BC_IDLE;
      cfg_q      <= '0;
      sc_q       <= '0;
      rc_q       <= '0;
      scalar_q   <= '0;
      zero_job_q <= 1'b0;
    end else if (abort_act) begin
      state_q <= BC_IDLE;
    end else begin
      unique case (state_q)
        BC_IDLE: begin
          if (cfg_hs) begin
            cfg_q      <= '{blen: cfg_blen_i, reps: cfg_reps_i};
            sc_q       <= '0;
            zero_job_q <= (cfg_blen_i == '0) || (cfg_reps_i == '0);
            state_q    <= ((cfg_blen_i == '0) || (cfg_reps_i == '0)) ? BC_DONE : BC_FETCH;
          end
        end
        BC_FETCH: begin
          if (fetch_hs) begin
            scalar_q <= bc_data_i[31:0];
            rc_q     <= '0;
            state_q  <= BC_ISSUE;
          end
        end
        BC_ISSUE: begin
          if (op_hs) begin
            if (!rep_last) begin
              rc_q <= rc_q + RepWidth'(1);
            end else if (scalar_last) begin
              state_q <= BC_DONE;
            end else begin
              // Bypass: the next scalar can be loaded in the same cycle, avoiding a bubble.
              sc_q <= sc_q + BLenWidth'(1);
              if (fetch_hs) begin
                scalar_q <= bc_data_i[31:0];
                rc_q     <= '0;
              end else begin
                state_q <= BC_FETCH;
              end
            end
          end
        end
        BC_DONE: state_q <= BC_IDLE;
        default: state_q <= BC_IDLE;
      endcase
    end
  end

  blen_legal_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  cfg_hs |-> (cfg_blen_i <= BLenWidth'(MaxBLen)))
    else $error("cfg_blen_i exceeds MaxBLen");

endmodule

// File: tb/tb_bc_operand_sequencer.sv
// Scoreboard bench for bc_operand_sequencer: a job-level model predicts the operand
// stream and job-end pulses, and a monitor compares them as the DUT produces them.
module tb_bc_operand_sequencer;
  import ara_pkg::*;

  localparam int MaxBLen  = 32;
  localparam int RepWidth = 16;
  localparam int BLenW    = $clog2(MaxBLen) + 1;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                cfg_valid_i = 1'b0;
  logic                cfg_ready_o;
  logic [BLenW-1:0]    cfg_blen_i = '0;
  logic [RepWidth-1:0] cfg_reps_i = '0;
  logic                abort_i = 1'b0;
  elen_t               bc_data_i = '0;
  logic                bc_data_valid_i = 1'b0;
  logic                bc_data_ready_o;
  logic                bc_data_invalidate_o;
  elen_t               operand_o;
  logic                operand_valid_o;
  logic                operand_ready_i = 1'b0;
  logic                operand_last_o;
  logic                done_o;
  logic                busy_o;

  bc_operand_sequencer #(.NrLanes(4), .MaxBLen(MaxBLen), .RepWidth(RepWidth)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_blen_i(cfg_blen_i), .cfg_reps_i(cfg_reps_i), .abort_i(abort_i),
    .bc_data_i(bc_data_i), .bc_data_valid_i(bc_data_valid_i),
    .bc_data_ready_o(bc_data_ready_o), .bc_data_invalidate_o(bc_data_invalidate_o),
    .operand_o(operand_o), .operand_valid_o(operand_valid_o),
    .operand_ready_i(operand_ready_i), .operand_last_o(operand_last_o),
    .done_o(done_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { elen_t op; logic last; } exp_op_t;
  typedef struct { logic done; logic inv; int pops; int ops; bit zero; bit nobubble; } exp_end_t;

  exp_op_t  exp_op_q[$];
  exp_end_t exp_end_q[$];
  elen_t    buf_q[$];

  int     n_cmp = 0, n_fail = 0;
  longint cyc = 0, cfg_cyc = 0, first_op_cyc = -1, last_op_cyc = 0;
  int     job_pops = 0, job_ops = 0;
  bit     pop_seen = 0, prev_stall = 0;
  elen_t  prev_op = '0;
  int     rdy_mode = 0;
  bit     valid_rand = 0;
  int     gap_at_pop = -1, gap_len = 0, gap_left = 0;
  logic [31:0] fixed_s [3];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Buffer and operand-queue models: present the head scalar, retire it after a pop.
  always @(posedge clk_i) begin
    if (pop_seen && buf_q.size() > 0) buf_q.delete(0);
    #2;
    case (rdy_mode)
      1:       operand_ready_i = 1'($urandom_range(0, 1));
      2:       operand_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: operand_ready_i = 1'b1;
    endcase
    if (gap_left > 0) begin
      gap_left--;
      bc_data_valid_i = 1'b0;
    end else begin
      bc_data_valid_i = (buf_q.size() > 0) && (!valid_rand || $urandom_range(0, 3) != 0);
    end
    bc_data_i = (buf_q.size() > 0) ? buf_q[0] : {$urandom, $urandom};
  end

  // Monitor: compare every operand handshake and job-end pulse against the scoreboard.
  always @(negedge clk_i) begin
    exp_op_t  e;
    exp_end_t ev;
    if (!rst_ni) begin
      prev_stall = 0;
      pop_seen   = 0;
    end else begin
      if (prev_stall && operand_valid_o) check_output("operand_stable", operand_o, prev_op);
      prev_stall = operand_valid_o && !operand_ready_i;
      prev_op    = operand_o;
      if (cfg_valid_i && cfg_ready_o) begin
        cfg_cyc = cyc; job_pops = 0; job_ops = 0; first_op_cyc = -1;
      end
      pop_seen = bc_data_valid_i && bc_data_ready_o;
      if (pop_seen) begin
        job_pops++;
        if (job_pops == gap_at_pop) gap_left = gap_len;
      end
      if (operand_valid_o && operand_ready_i) begin
        if (exp_op_q.size() == 0) check_output("unexpected_operand", operand_o, 64'd0);
        else begin
          e = exp_op_q.pop_front();
          check_output("operand_data", operand_o, e.op);
          check_output("operand_last", 64'(operand_last_o), 64'(e.last));
        end
        job_ops++;
        if (first_op_cyc < 0) first_op_cyc = cyc;
        last_op_cyc = cyc;
      end
      if (done_o || bc_data_invalidate_o) begin
        if (exp_end_q.size() == 0) check_output("unexpected_end", {done_o, bc_data_invalidate_o}, 64'd0);
        else begin
          ev = exp_end_q.pop_front();
          check_output("done_pulse", 64'(done_o), 64'(ev.done));
          check_output("invalidate_pulse", 64'(bc_data_invalidate_o), 64'(ev.inv));
          if (ev.pops >= 0) check_output("pop_count", 64'(job_pops), 64'(ev.pops));
          if (ev.ops >= 0) check_output("operand_count", 64'(job_ops), 64'(ev.ops));
          if (ev.done && ev.zero) check_output("zero_job_latency", 64'(cyc - cfg_cyc), 64'd1);
          if (ev.done && !ev.zero) check_output("done_latency", 64'(cyc - last_op_cyc), 64'd1);
          if (ev.nobubble) check_output("no_bubble_span", 64'(last_op_cyc - first_op_cyc), 64'(job_ops - 1));
        end
      end
    end
  end

  // Build the expected job from the rules, load the buffer, then hand the cfg to the DUT.
  task automatic apply_stimulus(input int blen, input int reps, input bit fixed,
                                input bit nobubble, input bit expect_end);
    logic [31:0] s;
    bit zero, ok;
    zero = (blen == 0) || (reps == 0);
    if (!zero) begin
      for (int i = 0; i < blen; i++) begin
        s = fixed ? fixed_s[i % 3] : $urandom;
        buf_q.push_back({$urandom, s});
        for (int r = 0; r < reps; r++)
          exp_op_q.push_back('{op: {s, s}, last: (i == blen - 1) && (r == reps - 1)});
      end
    end
    if (expect_end)
      exp_end_q.push_back('{done: 1'b1, inv: !zero, pops: zero ? 0 : blen,
                            ops: blen * reps, zero: zero, nobubble: nobubble});
    cfg_blen_i  = BLenW'(blen);
    cfg_reps_i  = RepWidth'(reps);
    cfg_valid_i = 1'b1;
    ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk_i);
      ok = cfg_ready_o;
      @(posedge clk_i); #1;
    end
    cfg_valid_i = 1'b0;
    if (!ok) check_output("cfg_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_job_end(input string tag);
    bit ok;
    ok = 0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk_i); #1;
      ok = (exp_end_q.size() == 0);
    end
    if (!ok) begin
      $display("[TB] FAIL %s: job end not seen within budget", tag);
      n_cmp++; n_fail++;
      exp_end_q.delete();
    end
    check_output({tag, "_ops_left"}, 64'(exp_op_q.size()), 64'd0);
    exp_op_q.delete();
    @(posedge clk_i); #1;
    check_output({tag, "_buffer_left"}, 64'(buf_q.size()), 64'd0);
    buf_q.delete();
  endtask

  task automatic wait_ops(input int n);
    bit ok;
    ok = 0;
    for (int t = 0; t < 500 && !ok; t++) begin
      @(negedge clk_i); #1;
      ok = (job_ops >= n);
    end
    if (!ok) check_output("wait_ops_timeout", 64'(job_ops), 64'(n));
    @(posedge clk_i); #1;
  endtask

  initial begin
    fixed_s[0] = 32'h3F80_0000;
    fixed_s[1] = 32'h4000_0000;
    fixed_s[2] = 32'h4040_0000;

    repeat (3) @(negedge clk_i);
    check_output("reset_cfg_ready", 64'(cfg_ready_o), 64'd1);
    check_output("reset_busy", 64'(busy_o), 64'd0);
    check_output("reset_operand_valid", 64'(operand_valid_o), 64'd0);
    check_output("reset_bc_ready", 64'(bc_data_ready_o), 64'd0);
    check_output("reset_outputs", {done_o, bc_data_invalidate_o, operand_last_o, operand_o}, 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    $display("[TB] back-to-back job, no stalls");
    apply_stimulus(3, 2, 1, 1, 1);
    wait_job_end("b2b");

    $display("[TB] buffer gap between scalars");
    gap_at_pop = 1; gap_len = 4;
    apply_stimulus(3, 2, 1, 0, 1);
    wait_job_end("gap");
    gap_at_pop = -1;

    $display("[TB] operand_ready pattern 1,0,0,1");
    rdy_mode = 2;
    apply_stimulus(3, 2, 1, 0, 1);
    wait_job_end("stall");
    rdy_mode = 0;

    $display("[TB] single scalar, single rep");
    apply_stimulus(1, 1, 0, 1, 1);
    wait_job_end("single");

    $display("[TB] zero-length jobs");
    apply_stimulus(0, 2, 0, 0, 1);
    wait_job_end("zero_blen");
    apply_stimulus(3, 0, 0, 0, 1);
    wait_job_end("zero_reps");

    $display("[TB] abort during scalar 2 of 4 with cfg_valid high");
    apply_stimulus(4, 3, 0, 0, 0);
    wait_ops(4);
    exp_end_q.push_back('{done: 1'b0, inv: 1'b1, pops: -1, ops: -1, zero: 1'b0, nobubble: 1'b0});
    abort_i = 1'b1; cfg_valid_i = 1'b1; cfg_blen_i = BLenW'(2); cfg_reps_i = RepWidth'(1);
    @(posedge clk_i); #1;
    abort_i = 1'b0; cfg_valid_i = 1'b0;
    exp_op_q.delete(); buf_q.delete();
    @(negedge clk_i);
    check_output("abort_busy", 64'(busy_o), 64'd0);
    check_output("abort_operand_valid", 64'(operand_valid_o), 64'd0);
    check_output("abort_end_seen", 64'(exp_end_q.size()), 64'd0);
    @(posedge clk_i); #1;
    apply_stimulus(2, 2, 0, 1, 1);
    wait_job_end("post_abort");

    $display("[TB] reset in the middle of a job");
    apply_stimulus(4, 2, 0, 0, 0);
    wait_ops(3);
    rst_ni = 1'b0;
    #1;
    check_output("midreset_busy", 64'(busy_o), 64'd0);
    check_output("midreset_invalidate", 64'(bc_data_invalidate_o), 64'd0);
    exp_op_q.delete(); buf_q.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    $display("[TB] maximum-length job with random handshakes");
    rdy_mode = 1; valid_rand = 1;
    apply_stimulus(MaxBLen, 1, 0, 0, 1);
    wait_job_end("max_blen");

    $display("[TB] random jobs");
    for (int j = 0; j < 12; j++) begin
      apply_stimulus($urandom_range(0, 9), $urandom_range(0, 4), 0, 0, 1);
      wait_job_end("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
